// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - opcode/funct3 constants, memory-stage state type and store lane helper
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_READ,
        S_FULL
    } mem_state_t;

    // Byte enables for a legal, aligned store of the given width at the given lane.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (f3)
            F3_B:    be = 4'b0001 << lane;
            F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port synchronous data RAM with byte enables, 1-cycle read latency
module dmem_sram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset; read data reflects the pre-write word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory stage: load/store to internal RAM, ALU pass-through, write-back bundle
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_wd,
    output logic            out_we,
    output logic            out_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_state_t state, state_nxt;

    logic        accept;
    logic [1:0]  lane;
    logic        is_load, is_store;
    logic        ld_f3_ok, st_f3_ok, misalign, mem_fault;
    logic        load_ok, store_ok;
    logic        ram_en;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata, ram_rdata;
    logic [1:0]  ld_lane;
    logic [2:0]  ld_f3;
    logic [31:0] ld_shift, ld_val;

    assign lane     = in_alu_result[1:0];
    assign is_load  = (in_opcode == OP_LOAD);
    assign is_store = (in_opcode == OP_STORE);
    assign ld_f3_ok = (in_funct3 == F3_B) || (in_funct3 == F3_H) || (in_funct3 == F3_W) ||
                      (in_funct3 == F3_BU) || (in_funct3 == F3_HU);
    assign st_f3_ok = (in_funct3 == F3_B) || (in_funct3 == F3_H) || (in_funct3 == F3_W);
    // funct3[1:0] encodes access width for both signed and unsigned forms
    assign misalign = ((in_funct3[1:0] == 2'b01) && lane[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (lane != 2'b00));
    assign mem_fault = (is_load && (!ld_f3_ok || misalign)) ||
                       (is_store && (!st_f3_ok || misalign));
    assign load_ok  = is_load && !mem_fault;
    assign store_ok = is_store && !mem_fault;

    assign out_valid = (state == S_FULL);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_EMPTY: in_ready = 1'b1;
            S_READ:  in_ready = 1'b0;
            S_FULL:  in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        case (state)
            S_EMPTY: if (accept) state_nxt = load_ok ? S_READ : S_FULL;
            S_READ:  state_nxt = S_FULL;
            S_FULL: begin
                if (out_ready) state_nxt = accept ? (load_ok ? S_READ : S_FULL) : S_EMPTY;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    // Stores commit in the accept cycle; loads issue their read in the accept cycle.
    assign ram_en = accept && (load_ok || store_ok);
    assign ram_be = (accept && store_ok) ? store_be(in_funct3, lane) : 4'b0000;

    always_comb begin
        ram_wdata = in_store_data[31:0];
        case (in_funct3[1:0])
            2'b00:   ram_wdata = {4{in_store_data[7:0]}};
            2'b01:   ram_wdata = {2{in_store_data[15:0]}};
            default: ram_wdata = in_store_data[31:0];
        endcase
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_dmem (
        .clk   (clk),
        .en    (ram_en),
        .be    (ram_be),
        .addr  (in_alu_result[AW+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign ld_shift = ram_rdata >> {ld_lane, 3'b000};

    always_comb begin
        ld_val = ld_shift;
        case (ld_f3)
            F3_B:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_H:    ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            F3_BU:   ld_val = {24'd0, ld_shift[7:0]};
            F3_HU:   ld_val = {16'd0, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_rd    <= '0;
            out_wd    <= '0;
            out_we    <= 1'b0;
            out_fault <= 1'b0;
            ld_lane   <= '0;
            ld_f3     <= '0;
        end else if (accept) begin
            out_rd    <= in_rd;
            out_wd    <= in_alu_result;
            out_fault <= mem_fault;
            // Loads set write enable once data returns; stores and faults never write.
            out_we    <= !is_load && !is_store && (in_rd != 5'd0);
            ld_lane   <= lane;
            ld_f3     <= in_funct3;
        end else if (state == S_READ) begin
            out_wd    <= XLEN'(ld_val);
            out_we    <= (out_rd != 5'd0);
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] IMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_store_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_rd;
    logic [31:0] out_wd;
    logic        out_we;
    logic        out_fault;

    int passed = 0;
    int total  = 0;

    logic [31:0] r_wd;
    logic        r_we, r_fault;
    int          r_edges;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32), .DEPTH_WORDS(256)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct3     (in_funct3),
        .in_rd         (in_rd),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd        (out_rd),
        .out_wd        (out_wd),
        .out_we        (out_we),
        .out_fault     (out_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one op into an empty stage, wait (bounded) for the bundle, capture it, let it drain.
    task automatic do_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sd);
        @(negedge clk);
        in_opcode = op; in_funct3 = f3; in_rd = rd;
        in_alu_result = addr; in_store_data = sd; in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        r_edges = 1;
        while (out_valid !== 1'b1 && r_edges < 5) begin
            @(posedge clk); #1;
            r_edges++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_rd"}, 32'(out_rd), 32'(rd));
        r_wd = out_wd; r_we = out_we; r_fault = out_fault;
        @(posedge clk); #1;
    endtask

    initial begin
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_we",    32'(out_we),    32'd0);
        check("rst_fault", 32'(out_fault), 32'd0);
        check("rst_rd",    32'(out_rd),    32'd0);
        check("rst_wd",    out_wd,         32'd0);
        @(negedge clk); reset = 1'b1;

        do_op("sw10", ST, 3'b010, 5'd1, 32'h10, 32'hDEADBEEF);
        check("sw10_we", 32'(r_we), 32'd0);
        check("sw10_fault", 32'(r_fault), 32'd0);
        check("sw10_lat", 32'(r_edges), 32'd1);

        do_op("lw10", LD, 3'b010, 5'd3, 32'h10, 32'h0);
        check("lw10_wd", r_wd, 32'hDEADBEEF);
        check("lw10_we", 32'(r_we), 32'd1);
        check("lw10_lat", 32'(r_edges), 32'd2);

        do_op("lb13", LD, 3'b000, 5'd4, 32'h13, 32'h0);
        check("lb13_wd", r_wd, 32'hFFFFFFDE);
        do_op("lbu13", LD, 3'b100, 5'd4, 32'h13, 32'h0);
        check("lbu13_wd", r_wd, 32'h000000DE);
        do_op("lh12", LD, 3'b001, 5'd4, 32'h12, 32'h0);
        check("lh12_wd", r_wd, 32'hFFFFDEAD);
        do_op("lhu12", LD, 3'b101, 5'd4, 32'h12, 32'h0);
        check("lhu12_wd", r_wd, 32'h0000DEAD);

        do_op("sb11", ST, 3'b000, 5'd0, 32'h11, 32'hABCDEF55);
        do_op("lw10b", LD, 3'b010, 5'd8, 32'h10, 32'h0);
        check("lw10b_wd", r_wd, 32'hDEAD55EF);
        do_op("lwwrap", LD, 3'b010, 5'd8, 32'h410, 32'h0);
        check("lwwrap_wd", r_wd, 32'hDEAD55EF);

        do_op("lw2", LD, 3'b010, 5'd9, 32'h2, 32'h0);
        check("lw2_fault", 32'(r_fault), 32'd1);
        check("lw2_we", 32'(r_we), 32'd0);
        check("lw2_lat", 32'(r_edges), 32'd1);

        do_op("sw0", ST, 3'b010, 5'd1, 32'h0, 32'h11223344);
        do_op("sh1", ST, 3'b001, 5'd1, 32'h1, 32'h0000AAAA);
        check("sh1_fault", 32'(r_fault), 32'd1);
        do_op("lw0", LD, 3'b010, 5'd2, 32'h0, 32'h0);
        check("lw0_wd", r_wd, 32'h11223344);
        check("lw0_fault", 32'(r_fault), 32'd0);

        do_op("ld011", LD, 3'b011, 5'd2, 32'h10, 32'h0);
        check("ld011_fault", 32'(r_fault), 32'd1);
        check("ld011_we", 32'(r_we), 32'd0);

        // Stall with out_ready low, then back-to-back ALU ops
        @(negedge clk);
        out_ready = 1'b0;
        in_opcode = IMM; in_funct3 = 3'b000; in_rd = 5'd5; in_alu_result = 32'h7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_rd = 5'd9; in_alu_result = 32'h99;
        check("alu_valid", 32'(out_valid), 32'd1);
        check("alu_we", 32'(out_we), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_wd", out_wd, 32'h7);
            check("stall_rd", 32'(out_rd), 32'd5);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_rd = 5'd6; in_alu_result = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_wd", out_wd, 32'h100 + 32'(i));
            check("b2b_rd", 32'(out_rd), 32'd6);
            in_alu_result = 32'h100 + 32'(i) + 32'd1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_drain", 32'(out_valid), 32'd0);

        // Reset while a load sits in S_READ
        @(negedge clk);
        in_opcode = LD; in_funct3 = 3'b010; in_rd = 5'd7; in_alu_result = 32'h10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rd_state_valid", 32'(out_valid), 32'd0);
        reset = 1'b0; #1;
        check("rst_read_valid", 32'(out_valid), 32'd0);
        check("rst_read_we", 32'(out_we), 32'd0);
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_read_nowb", 32'(out_valid), 32'd0);
        end

        // Reset while a bundle is held in S_FULL drops out_valid at once
        @(negedge clk);
        out_ready = 1'b0;
        in_opcode = IMM; in_rd = 5'd3; in_alu_result = 32'h55; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_valid", 32'(out_valid), 32'd1);
        reset = 1'b0; #1;
        check("rst_full_valid", 32'(out_valid), 32'd0);
        check("rst_full_wd", out_wd, 32'd0);
        @(negedge clk); reset = 1'b1; out_ready = 1'b1;

        do_op("lwx0", LD, 3'b010, 5'd0, 32'h10, 32'h0);
        check("lwx0_we", 32'(r_we), 32'd0);
        check("lwx0_wd", r_wd, 32'hDEAD55EF);

        do_op("alux0", IMM, 3'b000, 5'd0, 32'h1234, 32'h0);
        check("alux0_we", 32'(r_we), 32'd0);
        check("alux0_wd", r_wd, 32'h1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
